cpu_clock_ctrl: RTL
===================

Name: cpu_clock_ctrl

Overview:
Generates the CPU clock `cpu_clk` for the single-cycle MIPS core from the board clock. Supported modes: single-step (one pulse per debounced button press) and free-run (slow square wave). A PC breakpoint halts free-run. Sits between the button debouncers and the CPU core in the FPGA top level, and replaces driving the core clock directly from the button.

Parameters:
RUN_HALF, 50_000_000, board-clock cycles per half-period of `cpu_clk` in run mode (min 1)
PULSE_CYCLES, 1000, board-clock cycles `cpu_clk` stays high for one step (min 1)

Ports:
clk  in  1  board clock; all logic on its rising edge
reset  in  1  asynchronous, active-low; 0 = reset
step_btn  in  1  debounced step button, level
run_btn  in  1  debounced run/stop button, level
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint instruction address
pc  in  32  current CPU instruction address (currentIAddr)
cpu_clk  out  1  clock to CPU core, registered, glitch-free
running  out  1  1 in RUN_HI/RUN_LO
halted  out  1  1 after a breakpoint stop
cycle_count  out  16  number of `cpu_clk` rising edges (optional feature)

Behaviour:
- Reset (reset=0, async): state=IDLE, cpu_clk=0, running=0, halted=0, cycle_count=0, edge-detect regs=0, stop_req=0, timer=0.
- Edge detect: step_prev/run_prev are registered copies of the buttons. step_rise = step_btn & ~step_prev; run_rise = run_btn & ~run_prev.
- States: IDLE, STEP_HI, STEP_LO, RUN_HI, RUN_LO. `cpu_clk` is a register: 1 exactly in STEP_HI/RUN_HI.
- IDLE:
  - run_rise -> RUN_HI. Run wins if both rises occur in the same cycle.
  - else step_rise -> STEP_HI.
  - Either transition clears halted and loads the timer.
- STEP_HI: holds PULSE_CYCLES cycles, then -> STEP_LO.
- STEP_LO: holds while step_btn=1; -> IDLE on the first cycle step_btn=0. One press = one pulse regardless of hold time.
- RUN_HI: holds RUN_HALF cycles, then -> RUN_LO.
- RUN_LO: holds RUN_HALF cycles. On the last cycle, evaluated in priority order:
  - stop_req=1 -> IDLE, clear stop_req.
  - else bp_en=1 and pc==bp_addr (full 32-bit compare) -> IDLE, halted=1.
  - else -> RUN_HI.
- Breakpoint timing: checked only at the end of a full period, so the instruction at bp_addr has not executed when halted. Resuming from a halt always executes at least one instruction before the next check, so the controller never sticks on the same breakpoint.
- run_rise during RUN_HI/RUN_LO sets stop_req. The current period always completes, so `cpu_clk` never produces a truncated high or low phase.
- step_rise outside IDLE is ignored. run_rise during STEP_HI/STEP_LO is ignored.
- Latency: `cpu_clk` goes high on the clk edge that samples the rise (state transition edge). High width is exactly PULSE_CYCLES (step) or RUN_HALF (run).
- Timer: counts down from N-1 to 0, width clog2(max(RUN_HALF, PULSE_CYCLES)).
- Reset asserted mid-pulse: `cpu_clk` drops to 0 immediately (async).

Optional Feature:
CPU_CYCLE_COUNT_EN
- Defined: 16-bit cycle_count increments by 1 on every transition into STEP_HI or RUN_HI, and wraps 0xFFFF -> 0x0000. Cleared only by reset.
- Undefined: no counter register; cycle_count tied to 16'h0000.

Test Plan:
(RUN_HALF=4, PULSE_CYCLES=3, CPU_CYCLE_COUNT_EN defined)
1. Reset: hold reset=0 with buttons toggling -> cpu_clk=0, running=0, halted=0, cycle_count=0. Release -> still IDLE, cpu_clk=0.
2. Single-step: raise step_btn and hold 20 cycles -> exactly one cpu_clk pulse of 3 cycles, cycle_count=1. Release, press again -> second pulse, cycle_count=2.
3. Run/stop: run_btn pulse -> square wave, 4 high/4 low, running=1. Pulse run_btn during the 3rd high phase -> 3rd period finishes with full 4-cycle low, then cpu_clk=0, running=0, cycle_count=3.
4. Breakpoint: bp_en=1, bp_addr=0x0000000C; bench increments pc by 4 from 0x0 on each cpu_clk rise. Press run -> stops after 3rd period, pc=0x0C, halted=1, running=0. Press run again -> halted=0; next stop occurs only by run_btn (pc leaves 0x0C after 1st period).
5. Priority/ignore: step_btn and run_btn rise in the same cycle in IDLE -> run mode. Step presses during run -> no extra pulses or count change. Reset=0 during RUN_HI -> cpu_clk=0 within the same cycle.
6. Counter wrap: issue 65536 single steps -> cycle_count returns to 0x0000. Rebuild without macro -> cycle_count stays 0x0000 throughout.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Generates the CPU clock for the single-cycle MIPS core from the board
//   clock. Two modes:
//     - single-step : one PULSE_CYCLES-wide pulse per debounced step press
//     - free-run    : square wave, RUN_HALF cycles high / RUN_HALF low
//   A PC breakpoint, checked at the end of each full run period, halts
//   free-run before the instruction at bp_addr executes.
//
//   Optional feature macro: CPU_CYCLE_COUNT_EN
//     defined   -> 16-bit wrapping count of cpu_clk rising edges
//     undefined -> cycle_count tied to zero, no counter register
//
// Ports:
//   clk         in   board clock, all logic on its rising edge
//   reset       in   asynchronous active-low reset
//   step_btn    in   debounced step button (level)
//   run_btn     in   debounced run/stop button (level)
//   bp_en       in   breakpoint enable
//   bp_addr     in   breakpoint instruction address [31:0]
//   pc          in   current CPU instruction address [31:0]
//   cpu_clk     out  registered, glitch-free clock to the CPU core
//   running     out  1 while in free-run
//   halted      out  1 after a breakpoint stop
//   cycle_count out  number of cpu_clk rising edges [15:0]
module cpu_clock_ctrl #(
    parameter int RUN_HALF     = 50_000_000,
    parameter int PULSE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        run_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    output logic        cpu_clk,
    output logic        running,
    output logic        halted,
    output logic [15:0] cycle_count
);

    localparam int MAXN = (RUN_HALF > PULSE_CYCLES) ? RUN_HALF : PULSE_CYCLES;
    localparam int TW   = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam logic [TW-1:0] RUN_LOAD   = TW'(RUN_HALF - 1);
    localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP_HI = 3'd1,
        STEP_LO = 3'd2,
        RUN_HI  = 3'd3,
        RUN_LO  = 3'd4
    } state_t;

    state_t        r_state, w_next;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_step_prev, r_run_prev;
    logic          r_stop_req, w_stop_nxt;
    logic          r_halted;
    logic          r_cpu_clk, r_running;
    logic          w_step_rise, w_run_rise;
    logic          w_timer_done, w_bp_hit;
    logic          w_halt_set, w_halt_clr;
    logic          w_in_run;

    assign w_step_rise  = step_btn & ~r_step_prev;
    assign w_run_rise   = run_btn & ~r_run_prev;
    assign w_timer_done = (r_timer == '0);
    assign w_bp_hit     = bp_en && (pc == bp_addr);
    assign w_in_run     = (r_state == RUN_HI) || (r_state == RUN_LO);

    always_comb begin
        w_next      = r_state;
        w_timer_nxt = r_timer;
        w_halt_set  = 1'b0;
        w_halt_clr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_run_rise) begin
                    w_next      = RUN_HI;
                    w_timer_nxt = RUN_LOAD;
                    w_halt_clr  = 1'b1;
                end else if (w_step_rise) begin
                    w_next      = STEP_HI;
                    w_timer_nxt = PULSE_LOAD;
                    w_halt_clr  = 1'b1;
                end
            end
            STEP_HI: begin
                if (w_timer_done) w_next = STEP_LO;
                else              w_timer_nxt = r_timer - 1'b1;
            end
            STEP_LO: begin
                // Wait for release so a long press yields a single pulse.
                if (!step_btn) w_next = IDLE;
            end
            RUN_HI: begin
                if (w_timer_done) begin
                    w_next      = RUN_LO;
                    w_timer_nxt = RUN_LOAD;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            RUN_LO: begin
                // Stop/breakpoint only at the end of a full period so the
                // CPU never sees a truncated phase.
                if (w_timer_done) begin
                    if (r_stop_req) begin
                        w_next = IDLE;
                    end else if (w_bp_hit) begin
                        w_next     = IDLE;
                        w_halt_set = 1'b1;
                    end else begin
                        w_next      = RUN_HI;
                        w_timer_nxt = RUN_LOAD;
                    end
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Any return to IDLE drops a pending stop; a stop pressed on the very
    // last cycle of a breakpoint-halting period must not leak into the next run.
    always_comb begin
        w_stop_nxt = r_stop_req;
        if (w_next == IDLE)             w_stop_nxt = 1'b0;
        else if (w_in_run && w_run_rise) w_stop_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_step_prev <= 1'b0;
            r_run_prev  <= 1'b0;
            r_stop_req  <= 1'b0;
            r_halted    <= 1'b0;
            r_cpu_clk   <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_timer     <= w_timer_nxt;
            r_step_prev <= step_btn;
            r_run_prev  <= run_btn;
            r_stop_req  <= w_stop_nxt;
            if (w_halt_set)      r_halted <= 1'b1;
            else if (w_halt_clr) r_halted <= 1'b0;
            // Outputs decoded from next state into dedicated flops keep
            // cpu_clk free of decode glitches.
            r_cpu_clk   <= (w_next == STEP_HI) || (w_next == RUN_HI);
            r_running   <= (w_next == RUN_HI) || (w_next == RUN_LO);
        end
    end

    assign cpu_clk = r_cpu_clk;
    assign running = r_running;
    assign halted  = r_halted;

`ifdef CPU_CYCLE_COUNT_EN
    logic [15:0] r_cycle_count;
    logic        w_enter_hi;

    assign w_enter_hi = ((w_next == STEP_HI) && (r_state != STEP_HI)) ||
                        ((w_next == RUN_HI) && (r_state != RUN_HI));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_cycle_count <= 16'h0000;
        else if (w_enter_hi) r_cycle_count <= r_cycle_count + 16'h0001;
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 16'h0000;
`endif

endmodule
